// File: rtl/process_scheduler_pkg.sv
// Shared definitions for the round-robin process scheduler.
//   - default table geometry (slot count, pid/pc/quantum widths)
//   - FSM state encoding
//   - process-table entry type
package process_scheduler_pkg;

  localparam int NPROC_D = 4;
  localparam int PIDW_D  = 2;
  localparam int PCW_D   = 32;
  localparam int QW_D    = 32;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_RUN      = 3'd1;
  localparam logic [2:0] S_SAVE     = 3'd2;
  localparam logic [2:0] S_SELECT   = 3'd3;
  localparam logic [2:0] S_DISPATCH = 3'd4;

  typedef struct packed {
    logic              active;
    logic [PCW_D-1:0]  pc;
    logic [QW_D-1:0]   quantum;
  } entry_t;

endpackage

// File: rtl/process_scheduler_if.sv
// Scheduler bus: OS control (create), CPU status (interrupt/finish/halt/cur_pc)
// and the timer/PC redirect outputs.
//   master : OS/CPU side, drives requests and status, observes redirects
//   slave  : scheduler
interface process_scheduler_if #(
  parameter int PIDW = 2,
  parameter int PCW  = 32,
  parameter int QW   = 32
);
  logic            interrupt;
  logic            finish;
  logic            halt;
  logic [PCW-1:0]  cur_pc;
  logic            create;
  logic [PIDW-1:0] create_pid;
  logic [PCW-1:0]  create_pc;
  logic [QW-1:0]   create_q;
  logic            create_ack;
  logic            FLAG_timer;
  logic [QW-1:0]   quantum;
  logic            pc_load;
  logic [PCW-1:0]  pc_value;
  logic [PIDW-1:0] cur_pid;
  logic            running;
  logic            idle;

  modport master (
    output interrupt, finish, halt, cur_pc, create, create_pid, create_pc, create_q,
    input  create_ack, FLAG_timer, quantum, pc_load, pc_value, cur_pid, running, idle
  );

  modport slave (
    input  interrupt, finish, halt, cur_pc, create, create_pid, create_pc, create_q,
    output create_ack, FLAG_timer, quantum, pc_load, pc_value, cur_pid, running, idle
  );
endinterface

// File: rtl/process_scheduler_rr_picker.sv
// Round-robin picker: scans the active mask starting at 'start', wrapping
// modulo NPROC; the first set bit wins.
//   mask  : active slots
//   start : first slot examined
//   found : some slot is active
//   sel   : chosen slot (0 when none found)
module rr_picker #(
  parameter int NPROC = 4,
  parameter int PIDW  = 2
) (
  input  logic [NPROC-1:0] mask,
  input  logic [PIDW-1:0]  start,
  output logic             found,
  output logic [PIDW-1:0]  sel
);

  logic [PIDW-1:0] idx;

  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = '0;
    for (int i = 0; i < NPROC; i++) begin
      // NPROC is a power of two, so the PIDW-bit add wraps for free
      idx = start + PIDW'(i);
      if (!found && mask[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

endmodule

// File: rtl/process_scheduler.sv
// Round-robin preemptive process scheduler.
// Holds a per-slot table (active, saved PC, quantum). On a timer interrupt it
// saves the running PC; on finish it frees the slot. Either way it picks the
// next active slot after the current one and, in DISPATCH, redirects the PC
// and re-arms the timer with that slot's quantum.
//   clock, reset : system clock, async active-high reset
//   bus          : scheduler bus, slave side (see process_scheduler_if)
module process_scheduler
  import process_scheduler_pkg::*;
#(
  parameter int NPROC = NPROC_D,
  parameter int PIDW  = PIDW_D,
  parameter int PCW   = PCW_D,
  parameter int QW    = QW_D
) (
  input  logic                 clock,
  input  logic                 reset,
  process_scheduler_if.slave   bus
);

  logic [2:0]       state;
  logic [NPROC-1:0] active;
  logic [PCW-1:0]   pc_tab [NPROC];
  logic [QW-1:0]    q_tab  [NPROC];
  logic [PIDW-1:0]  cur_pid_q;
  logic [PIDW-1:0]  sel_q;
  logic             ack_q;

  logic [PIDW-1:0]  start_pid;
  logic             pick_found;
  logic [PIDW-1:0]  pick_sel;
  logic             create_ok;

  // search begins after the running slot so the current one comes last
  assign start_pid = cur_pid_q + PIDW'(1);

  rr_picker #(.NPROC(NPROC), .PIDW(PIDW)) u_pick (
    .mask  (active),
    .start (start_pid),
    .found (pick_found),
    .sel   (pick_sel)
  );

  // a slot can only be claimed while free and not being saved this cycle
  assign create_ok = bus.create && !active[bus.create_pid] &&
                     !(state == S_SAVE && bus.create_pid == cur_pid_q);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      active    <= '0;
      cur_pid_q <= '0;
      sel_q     <= '0;
      ack_q     <= 1'b0;
      for (int i = 0; i < NPROC; i++) begin
        pc_tab[i] <= '0;
        q_tab[i]  <= '0;
      end
    end else begin
      ack_q <= create_ok;
      if (create_ok) begin
        active[bus.create_pid] <= 1'b1;
        pc_tab[bus.create_pid] <= bus.create_pc;
        q_tab[bus.create_pid]  <= bus.create_q;
      end

      case (state)
        S_IDLE: begin
          if (|active) state <= S_SELECT;
        end
        S_RUN: begin
          // finish outranks a coincident interrupt: the slot is gone, no save
          if (bus.finish) begin
            active[cur_pid_q] <= 1'b0;
            state             <= S_SELECT;
          end else if (bus.interrupt && !bus.halt) begin
            state <= S_SAVE;
          end
        end
        S_SAVE: begin
          pc_tab[cur_pid_q] <= bus.cur_pc;
          state             <= S_SELECT;
        end
        S_SELECT: begin
          if (pick_found) begin
            sel_q <= pick_sel;
            state <= S_DISPATCH;
          end else begin
            state <= S_IDLE;
          end
        end
        S_DISPATCH: begin
          cur_pid_q <= sel_q;
          state     <= S_RUN;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // redirect strobes are decoded from state so reset drops them at once
  assign bus.pc_load    = (state == S_DISPATCH);
  assign bus.FLAG_timer = (state == S_DISPATCH);
  assign bus.pc_value   = bus.pc_load ? pc_tab[sel_q] : '0;
  assign bus.quantum    = bus.pc_load ? q_tab[sel_q]  : '0;
  assign bus.create_ack = ack_q;
  assign bus.cur_pid    = cur_pid_q;
  assign bus.running    = (state == S_RUN);
  assign bus.idle       = (state == S_IDLE);

endmodule

// File: tb/tb_process_scheduler.sv
module tb_process_scheduler;
  import process_scheduler_pkg::*;

  localparam int NP = 4;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  process_scheduler_if #(.PIDW(2), .PCW(32), .QW(32)) bus();

  process_scheduler #(.NPROC(NP), .PIDW(2), .PCW(32), .QW(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int          cyc;
    logic [31:0] pc;
    logic [31:0] q;
    int          pid;
    bit          idle;
    bit          run;
    bit          zero;
  } exp_t;

  exp_t ackq[$], dspq[$], stq[$];
  int   cyc = 0;
  int   checks = 0;
  int   passed = 0;

  // reference model: process table plus who is running
  entry_t tab[NP];
  int     m_cur;
  bit     m_run;
  bit     pend_v;
  int     pend_pid;

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  task automatic chk(string name, longint act, longint exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // monitor: compares DUT outputs against queued expectations
  initial forever begin
    @(negedge clock);
    if (pend_v) begin
      chk("cur_pid_after_dispatch", bus.cur_pid, pend_pid);
      chk("running_after_dispatch", bus.running, 1);
      pend_v = 0;
    end
    if (ackq.size() > 0 && ackq[0].cyc == cyc) begin
      chk("create_ack", bus.create_ack, 1);
      void'(ackq.pop_front());
    end else if (bus.create_ack) begin
      chk("create_ack_spurious", bus.create_ack, 0);
    end
    if (dspq.size() > 0 && dspq[0].cyc == cyc) begin
      chk("pc_load", bus.pc_load, 1);
      chk("FLAG_timer", bus.FLAG_timer, 1);
      chk("pc_value", bus.pc_value, dspq[0].pc);
      chk("quantum", bus.quantum, dspq[0].q);
      pend_v   = 1;
      pend_pid = dspq[0].pid;
      void'(dspq.pop_front());
    end else if (bus.pc_load) begin
      chk("pc_load_spurious", bus.pc_load, 0);
    end
    while (stq.size() > 0 && stq[0].cyc == cyc) begin
      chk("idle", bus.idle, stq[0].idle);
      chk("running", bus.running, stq[0].run);
      chk("cur_pid", bus.cur_pid, stq[0].pid);
      if (stq[0].zero) begin
        chk("rst_pc_load", bus.pc_load, 0);
        chk("rst_FLAG_timer", bus.FLAG_timer, 0);
        chk("rst_pc_value", bus.pc_value, 0);
        chk("rst_quantum", bus.quantum, 0);
        chk("rst_create_ack", bus.create_ack, 0);
      end
      void'(stq.pop_front());
    end
  end

  function automatic int pick();
    for (int k = 1; k <= NP; k++) begin
      int p;
      p = (m_cur + k) % NP;
      if (tab[p].active) return p;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NP; i++) tab[i] = '0;
    m_cur = 0;
    m_run = 0;
  endtask

  task automatic push_dsp(int c, int p);
    exp_t e;
    e = '{cyc: c, pc: tab[p].pc, q: tab[p].quantum, pid: p, idle: 0, run: 1, zero: 0};
    dspq.push_back(e);
    m_cur = p;
    m_run = 1;
  endtask

  task automatic settle();
    repeat (6) @(posedge clock);
  endtask

  task automatic do_status();
    exp_t e;
    @(posedge clock); #1;
    e = '{cyc: cyc, pc: 0, q: 0, pid: m_cur, idle: !m_run, run: m_run, zero: 0};
    stq.push_back(e);
    @(posedge clock);
  endtask

  task automatic do_create(int pid, logic [31:0] pc, logic [31:0] q);
    int   c;
    exp_t e;
    @(posedge clock); #1;
    bus.create = 1; bus.create_pid = 2'(pid); bus.create_pc = pc; bus.create_q = q;
    c = cyc;
    if (!tab[pid].active) begin
      e = '{cyc: c + 1, pc: 0, q: 0, pid: pid, idle: 0, run: 0, zero: 0};
      ackq.push_back(e);
      tab[pid].active = 1; tab[pid].pc = pc; tab[pid].quantum = q;
      if (!m_run) push_dsp(c + 3, pick());
    end
    @(posedge clock); #1;
    bus.create = 0;
    settle();
  endtask

  task automatic do_run(bit intr, bit fin, bit hlt, logic [31:0] pc);
    int c, p;
    @(posedge clock); #1;
    bus.interrupt = intr; bus.finish = fin; bus.halt = hlt; bus.cur_pc = pc;
    c = cyc;
    if (m_run) begin
      if (fin) begin
        tab[m_cur].active = 0;
        p = pick();
        if (p >= 0) push_dsp(c + 2, p);
        else m_run = 0;
      end else if (intr && !hlt) begin
        tab[m_cur].pc = pc;
        push_dsp(c + 3, pick());
      end
    end
    @(posedge clock); #1;
    bus.interrupt = 0; bus.finish = 0; bus.halt = 0;
    settle();
  endtask

  task automatic do_reset_in_save(logic [31:0] pc);
    exp_t e;
    @(posedge clock); #1;
    bus.interrupt = 1; bus.cur_pc = pc;
    @(posedge clock); #1;          // DUT now in SAVE
    bus.interrupt = 0;
    reset = 1;
    model_reset();
    pend_v = 0;
    e = '{cyc: cyc, pc: 0, q: 0, pid: 0, idle: 1, run: 0, zero: 1};
    stq.push_back(e);
    repeat (2) @(posedge clock); #1;
    reset = 0;
    settle();
  endtask

  initial begin
    exp_t e;
    model_reset();
    pend_v = 0;
    reset = 1;
    bus.interrupt = 0; bus.finish = 0; bus.halt = 0; bus.cur_pc = '0;
    bus.create = 0; bus.create_pid = '0; bus.create_pc = '0; bus.create_q = '0;
    repeat (2) @(posedge clock); #1;
    e = '{cyc: cyc, pc: 0, q: 0, pid: 0, idle: 1, run: 0, zero: 1};
    stq.push_back(e);
    @(posedge clock); #1;
    reset = 0;
    do_status();

    // first dispatch out of IDLE
    do_create(0, 32'h100, 32'd10);
    do_status();
    // three-way rotation, saved PC comes back on wrap
    do_create(1, 32'h200, 32'd20);
    do_create(2, 32'h300, 32'd30);
    do_run(1, 0, 0, 32'h140);
    do_status();
    do_run(1, 0, 0, 32'h240);
    do_run(1, 0, 0, 32'h340);
    // create to an active slot is ignored
    do_create(0, 32'h999, 32'd5);
    // finish beats interrupt; then halt masks interrupt
    do_run(1, 1, 0, 32'h180);
    do_status();
    do_run(1, 0, 1, 32'h260);
    do_status();
    do_run(0, 1, 0, 32'h0);
    do_run(0, 1, 0, 32'h0);
    do_status();
    // wrap from pid3 to pid0 and back; quantum 0 slot
    do_create(3, 32'h400, 32'd0);
    do_create(0, 32'h500, 32'd7);
    do_run(1, 0, 0, 32'h440);
    do_run(1, 0, 0, 32'h540);
    do_status();
    // last process finishes -> IDLE, then recreate
    do_run(0, 1, 0, 32'h0);
    do_run(0, 1, 0, 32'h0);
    do_create(1, 32'h600, 32'd3);
    do_run(0, 1, 0, 32'h0);
    do_status();
    do_create(1, 32'h700, 32'd4);
    do_status();

    // randomized operation mix
    for (int n = 0; n < 80; n++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r <= 3) do_create($urandom_range(0, NP - 1), $urandom & 32'hFFFF_FFFC, $urandom_range(0, 50));
      else if (r <= 6) do_run(1, 0, 0, $urandom & 32'hFFFF_FFFC);
      else if (r <= 8) do_run(0, 1, 0, 32'h0);
      else do_status();
    end

    // reset while saving drops the pending redirect
    if (!m_run) do_create(0, 32'h1000, 32'd6);
    do_reset_in_save(32'h1040);
    do_status();
    do_create(2, 32'h800, 32'd9);
    do_status();

    settle();
    chk("ack_queue_drained", ackq.size(), 0);
    chk("dispatch_queue_drained", dspq.size(), 0);
    chk("status_queue_drained", stq.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
